// File: rtl/ise_feed_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ise_feed_ctrl_if
// Brief    : Bundle of the start, pixel-ROM, sorting-engine and result-buffer
//            signals around ise_feed_ctrl. The master modport is the
//            sequencer; the slave modport is the system/engine side.
// Revision : 1.0 - initial release
// ============================================================================
interface ise_feed_ctrl_if #(
   parameter int IMG_NUM = 32,
   parameter int PIX_NUM = 16384
);
   localparam int IMG_W = $clog2(IMG_NUM);
   localparam int PIX_W = $clog2(PIX_NUM);

   logic                   start;
   logic                   rom_rd;
   logic [IMG_W+PIX_W-1:0] rom_addr;
   logic [23:0]            rom_data;
   logic                   eng_busy;
   logic [IMG_W-1:0]       eng_image_in_index;
   logic [23:0]            eng_pixel;
   logic                   eng_out_valid;
   logic [1:0]             eng_color_index;
   logic [IMG_W-1:0]       eng_image_out_index;
   logic [IMG_W-1:0]       res_raddr;
   logic [IMG_W+1:0]       res_rdata;
   logic [IMG_W:0]         res_cnt;
   logic                   done;
   logic                   err_underrun;
   logic                   err_early;
   logic                   err_count;

   modport master (
      input  start, rom_data, eng_busy, eng_out_valid, eng_color_index,
             eng_image_out_index, res_raddr,
      output rom_rd, rom_addr, eng_image_in_index, eng_pixel, res_rdata,
             res_cnt, done, err_underrun, err_early, err_count
   );

   modport slave (
      output start, rom_data, eng_busy, eng_out_valid, eng_color_index,
             eng_image_out_index, res_raddr,
      input  rom_rd, rom_addr, eng_image_in_index, eng_pixel, res_rdata,
             res_cnt, done, err_underrun, err_early, err_count
   );
endinterface
`default_nettype wire

// File: rtl/ise_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ise_feed_ctrl
// Brief    : Host-side sequencer for the image sorting engine. Prefetches
//            pixels from a 1-cycle-latency ROM into a 2-entry FIFO, feeds the
//            engine under busy flow control, captures the sorted results and
//            reports completion and protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module ise_feed_ctrl #(
   parameter int IMG_NUM = 32,
   parameter int PIX_NUM = 16384,
   parameter int TIMEOUT = 65535
) (
   input  wire logic       clk,
   input  wire logic       reset,
   ise_feed_ctrl_if.master bus
);
   localparam int IMG_W = $clog2(IMG_NUM);
   localparam int PIX_W = $clog2(PIX_NUM);
   localparam int AW    = IMG_W + PIX_W;
   localparam int EW    = IMG_W + 24;          // FIFO entry {image, pixel}
   localparam int RW    = IMG_W + 2;           // result entry {color, image}
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   localparam logic [AW:0]      TOTAL    = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]      LAST_POP = {1'b0, {AW{1'b1}}};
   localparam logic [IMG_W:0]   RES_FULL = {1'b1, {IMG_W{1'b0}}};
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [AW:0]                rd_ptr_q, rd_ptr_d;
   logic [AW:0]                pop_cnt_q, pop_cnt_d;
   logic                       pend_q, pend_d;        // ROM read in flight
   logic [IMG_W-1:0]           pend_idx_q, pend_idx_d;
   logic [1:0][EW-1:0]         fifo_q, fifo_d;        // entry 0 is the head
   logic [1:0]                 occ_q, occ_d;
   logic [IMG_W:0]             res_cnt_q, res_cnt_d;
   logic [IMG_NUM-1:0][RW-1:0] res_buf_q, res_buf_d;
   logic [WD_W-1:0]            wdog_q, wdog_d;
   logic                       seen_busy_q, seen_busy_d;
   logic                       err_underrun_q, err_underrun_d;
   logic                       err_early_q, err_early_d;
   logic                       err_count_q, err_count_d;

   logic                       rom_rd;
   logic                       pop;
   logic [EW-1:0]              new_entry;

   assign new_entry = {pend_idx_q, bus.rom_data};

   // Next-state, prefetch/pop control, result capture and error flags
   always_comb begin
      state_d        = state_q;
      rd_ptr_d       = rd_ptr_q;
      pop_cnt_d      = pop_cnt_q;
      pend_d         = 1'b0;
      pend_idx_d     = pend_idx_q;
      fifo_d         = fifo_q;
      occ_d          = occ_q;
      res_cnt_d      = res_cnt_q;
      res_buf_d      = res_buf_q;
      wdog_d         = wdog_q;
      seen_busy_d    = seen_busy_q;
      err_underrun_d = err_underrun_q;
      err_early_d    = err_early_q;
      err_count_d    = err_count_q;
      rom_rd         = 1'b0;
      pop            = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d        = S_FEED;
               rd_ptr_d       = '0;
               pop_cnt_d      = '0;
               res_cnt_d      = '0;
               err_underrun_d = 1'b0;
               err_early_d    = 1'b0;
               err_count_d    = 1'b0;
            end
         end

         S_FEED: begin
            pop = !bus.eng_busy && (occ_q != 2'd0);
            // The two fill cycles after start are exempt: no pop has happened yet.
            if (!bus.eng_busy && (occ_q == 2'd0) && (pop_cnt_q != '0))
               err_underrun_d = 1'b1;
            // Counting this cycle's pop as freed space keeps 1 pixel/cycle
            // with one entry held and one read in flight.
            rom_rd = (rd_ptr_q < TOTAL) &&
                     (({1'b0, occ_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop}));
            if (rom_rd) begin
               rd_ptr_d   = rd_ptr_q + 1'b1;
               pend_d     = 1'b1;
               pend_idx_d = rd_ptr_q[AW-1:PIX_W];
            end
            if (pop) begin
               pop_cnt_d = pop_cnt_q + 1'b1;
               if (pop_cnt_q == LAST_POP) begin
                  state_d     = S_DRAIN;
                  wdog_d      = '0;
                  seen_busy_d = 1'b0;
               end
            end
         end

         S_DRAIN: begin
            wdog_d = wdog_q + 1'b1;
            if (bus.eng_busy)
               seen_busy_d = 1'b1;
            if (bus.eng_out_valid) begin
               if (res_cnt_q == RES_FULL) begin
                  err_count_d = 1'b1;
               end else begin
                  res_buf_d[res_cnt_q[IMG_W-1:0]] = {bus.eng_color_index, bus.eng_image_out_index};
                  res_cnt_d = res_cnt_q + 1'b1;
               end
            end
            if (!bus.eng_busy && seen_busy_q) begin
               state_d = S_DONE;
               if (res_cnt_d != RES_FULL)
                  err_count_d = 1'b1;
            end else if (wdog_q == WD_LAST) begin
               state_d     = S_DONE;
               err_count_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Results are only legal while draining; a start in the same cycle does not mask it.
      if (bus.eng_out_valid && (state_q != S_DRAIN))
         err_early_d = 1'b1;

      // FIFO update; a push only ever lands when at most one entry is held.
      case ({pend_q, pop})
         2'b10: begin
            fifo_d[occ_q[0]] = new_entry;
            occ_d            = occ_q + 2'd1;
         end
         2'b01: begin
            fifo_d[0] = fifo_q[1];
            occ_d     = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd2) begin
               fifo_d[0] = fifo_q[1];
               fifo_d[1] = new_entry;
            end else begin
               fifo_d[0] = new_entry;
            end
         end
         default: ;
      endcase
   end

   // State registers with asynchronous abort of any run in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         rd_ptr_q       <= '0;
         pop_cnt_q      <= '0;
         pend_q         <= 1'b0;
         pend_idx_q     <= '0;
         fifo_q         <= '0;
         occ_q          <= '0;
         res_cnt_q      <= '0;
         res_buf_q      <= '0;
         wdog_q         <= '0;
         seen_busy_q    <= 1'b0;
         err_underrun_q <= 1'b0;
         err_early_q    <= 1'b0;
         err_count_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         rd_ptr_q       <= rd_ptr_d;
         pop_cnt_q      <= pop_cnt_d;
         pend_q         <= pend_d;
         pend_idx_q     <= pend_idx_d;
         fifo_q         <= fifo_d;
         occ_q          <= occ_d;
         res_cnt_q      <= res_cnt_d;
         res_buf_q      <= res_buf_d;
         wdog_q         <= wdog_d;
         seen_busy_q    <= seen_busy_d;
         err_underrun_q <= err_underrun_d;
         err_early_q    <= err_early_d;
         err_count_q    <= err_count_d;
      end
   end

   assign bus.rom_rd             = rom_rd;
   assign bus.rom_addr           = rd_ptr_q[AW-1:0];
   assign bus.eng_pixel          = (occ_q != 2'd0) ? fifo_q[0][23:0] : 24'd0;
   assign bus.eng_image_in_index = (occ_q != 2'd0) ? fifo_q[0][EW-1:24] : '0;
   assign bus.res_rdata          = res_buf_q[bus.res_raddr];
   assign bus.res_cnt            = res_cnt_q;
   assign bus.done               = (state_q == S_DONE);
   assign bus.err_underrun       = err_underrun_q;
   assign bus.err_early          = err_early_q;
   assign bus.err_count          = err_count_q;
endmodule
`default_nettype wire

// File: tb/tb_ise_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ise_feed_ctrl
// Brief    : Self-checking bench for ise_feed_ctrl with a small image set,
//            randomized pixels/results/backpressure and a behavioural model
//            of the pixel stream and result buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ise_feed_ctrl;
   localparam int IMG_NUM = 2;
   localparam int PIX_NUM = 4;
   localparam int TIMEOUT = 10;
   localparam int IMG_W   = $clog2(IMG_NUM);
   localparam int PIX_W   = $clog2(PIX_NUM);
   localparam int AW      = IMG_W + PIX_W;
   localparam int TOTAL   = IMG_NUM * PIX_NUM;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   logic [23:0]      rom     [TOTAL];
   logic [1:0]       res_col [4];
   logic [IMG_W-1:0] res_img [4];

   ise_feed_ctrl_if #(.IMG_NUM(IMG_NUM), .PIX_NUM(PIX_NUM)) bus ();

   ise_feed_ctrl #(.IMG_NUM(IMG_NUM), .PIX_NUM(PIX_NUM), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Pixel ROM: one cycle of read latency, junk on the bus when not read
   always @(posedge clk)
      bus.rom_data <= bus.rom_rd ? rom[bus.rom_addr] : 24'($urandom);

   task automatic fill_rom();
      for (int i = 0; i < TOTAL; i++) rom[i] = 24'($urandom);
   endtask

   task automatic rand_results();
      for (int i = 0; i < 4; i++) begin
         res_col[i] = 2'($urandom);
         res_img[i] = IMG_W'($urandom);
      end
   endtask

   // Start a run and play the engine side of FEED. The expected stream is
   // the ROM in address order; the first pixel shows up two cycles after
   // start and then one is ready every cycle the engine is not busy.
   task automatic do_feed(input int mode, input bit early, input int stop_pops, output int cycles);
      int issued = 0;
      int popped = 0;
      int cyc = 0;
      bit pop_now;
      logic [23:0] exp_pix;
      logic [IMG_W-1:0] exp_idx;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (popped < stop_pops && cyc < 200) begin
         case (mode)
            0:       bus.eng_busy = 1'b0;
            1:       bus.eng_busy = !(((cyc % 5) == 1) || ((cyc % 5) == 4));
            default: bus.eng_busy = 1'($urandom_range(0, 1));
         endcase
         bus.eng_out_valid       = early && (cyc == 4);
         bus.eng_color_index     = 2'($urandom);
         bus.eng_image_out_index = IMG_W'($urandom);
         @(negedge clk);
         if (cyc == 0) begin
            vectors++;
            if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== '0) begin
               miscompares++;
               $display("FAIL start_clears: got done/cnt/flags %b expected 0",
                        {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count});
            end
         end
         pop_now = !bus.eng_busy && (cyc >= 2);
         if (bus.rom_rd === 1'b1) begin
            vectors++;
            if (issued >= TOTAL || bus.rom_addr !== AW'(issued)) begin
               miscompares++;
               $display("FAIL rom_addr: got %0d expected %0d (reads so far %0d)", bus.rom_addr, issued, issued);
            end
            issued++;
         end
         vectors++;
         if (issued - popped - int'(pop_now) > 2) begin
            miscompares++;
            $display("FAIL in_flight: got %0d reads outstanding expected at most 2", issued - popped - int'(pop_now));
         end
         exp_pix = (cyc >= 2) ? rom[popped] : 24'd0;
         exp_idx = (cyc >= 2) ? IMG_W'(popped / PIX_NUM) : '0;
         vectors++;
         if (bus.eng_pixel !== exp_pix || bus.eng_image_in_index !== exp_idx) begin
            miscompares++;
            $display("FAIL presented_pixel cyc %0d: got %h/img %0d expected %h/img %0d",
                     cyc, bus.eng_pixel, bus.eng_image_in_index, exp_pix, exp_idx);
         end
         if (pop_now) popped++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.eng_out_valid = 1'b0;
      bus.eng_busy      = 1'b1;
      if (popped < stop_pops) begin
         vectors++;
         miscompares++;
         $display("FAIL feed_timeout: got %0d pops expected %0d", popped, stop_pops);
      end
      cycles = cyc;
   endtask

   // Play the engine in DRAIN: nbusy idle busy cycles, nres results while
   // busy, then busy drops; afterwards check DONE and the captured buffer.
   task automatic do_drain(input int nbusy, input int nres);
      int ncap;
      int k;
      for (int i = 0; i < nbusy + nres + 1; i++) begin
         k = i - nbusy;
         bus.eng_busy      = (i < nbusy + nres);
         bus.eng_out_valid = (k >= 0) && (k < nres);
         if (k >= 0 && k < nres) begin
            bus.eng_color_index     = res_col[k];
            bus.eng_image_out_index = res_img[k];
         end
         @(negedge clk);
         vectors++;
         if (bus.rom_rd !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_cycle %0d: got rom_rd %b done %b expected 0 0", i, bus.rom_rd, bus.done);
         end
         @(posedge clk); #1;
      end
      bus.eng_out_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_after_drain: got %b expected 1", bus.done);
      end
      ncap = (nres < IMG_NUM) ? nres : IMG_NUM;
      for (int i = 0; i < ncap; i++) begin
         bus.res_raddr = IMG_W'(i);
         #1;
         vectors++;
         if (bus.res_rdata !== {res_col[i], res_img[i]}) begin
            miscompares++;
            $display("FAIL res_buf[%0d]: got %b expected %b", i, bus.res_rdata, {res_col[i], res_img[i]});
         end
      end
   endtask

   task automatic test_reset();
      bus.res_raddr = IMG_W'($urandom);
      @(posedge clk); #1;
      vectors++;
      if ({bus.rom_rd, bus.rom_addr, bus.eng_pixel, bus.eng_image_in_index, bus.res_rdata,
           bus.res_cnt, bus.done, bus.err_underrun, bus.err_early, bus.err_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rom_rd %b addr %0d pix %h res %b cnt %0d done %b flags %b expected all 0",
                  bus.rom_rd, bus.rom_addr, bus.eng_pixel, bus.res_rdata, bus.res_cnt, bus.done,
                  {bus.err_underrun, bus.err_early, bus.err_count});
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_run();
      int cyc;
      fill_rom();
      res_col[0] = 2'd1; res_img[0] = IMG_W'(1);
      res_col[1] = 2'd0; res_img[1] = IMG_W'(0);
      do_feed(0, 1'b0, TOTAL, cyc);
      vectors++;
      if (cyc !== 2 + TOTAL) begin
         miscompares++;
         $display("FAIL full_run_feed_cycles: got %0d expected %0d", cyc, 2 + TOTAL);
      end
      do_drain(5, 2);
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd2, 3'b000}) begin
         miscompares++;
         $display("FAIL full_run_status: got %b expected %b",
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd2, 3'b000});
      end
      @(posedge clk); #1;
   endtask

   // mode 1: fixed 1,0,1,1,0 busy pattern; mode 2: random busy
   task automatic test_backpressure(input int mode);
      int cyc;
      fill_rom();
      rand_results();
      do_feed(mode, 1'b0, TOTAL, cyc);
      do_drain(2, 2);
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd2, 3'b000}) begin
         miscompares++;
         $display("FAIL backpressure_status mode %0d: got %b expected %b", mode,
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd2, 3'b000});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_short_results();
      int cyc;
      fill_rom();
      rand_results();
      do_feed(2, 1'b0, TOTAL, cyc);
      do_drain(3, 1);
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd1, 3'b001}) begin
         miscompares++;
         $display("FAIL short_results_status: got %b expected %b",
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd1, 3'b001});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      int cyc;
      fill_rom();
      rand_results();
      do_feed(0, 1'b0, TOTAL, cyc);
      do_drain(2, 3);
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd2, 3'b001}) begin
         miscompares++;
         $display("FAIL overflow_status: got %b expected %b",
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd2, 3'b001});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_early_result();
      int cyc;
      fill_rom();
      rand_results();
      do_feed(1, 1'b1, TOTAL, cyc);
      vectors++;
      if (bus.err_early !== 1'b1 || bus.res_cnt !== '0) begin
         miscompares++;
         $display("FAIL early_in_feed: got err_early %b res_cnt %0d expected 1 0", bus.err_early, bus.res_cnt);
      end
      do_drain(3, 2);
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd2, 3'b010}) begin
         miscompares++;
         $display("FAIL early_result_status: got %b expected %b",
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd2, 3'b010});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_feed();
      int cyc;
      fill_rom();
      do_feed(0, 1'b0, 3, cyc);
      reset = 1'b0;
      #1;
      vectors++;
      if ({bus.rom_rd, bus.rom_addr, bus.eng_pixel, bus.eng_image_in_index, bus.res_rdata,
           bus.res_cnt, bus.done, bus.err_underrun, bus.err_early, bus.err_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_feed_outputs: got rom_rd %b addr %0d pix %h res %b cnt %0d done %b expected all 0",
                  bus.rom_rd, bus.rom_addr, bus.eng_pixel, bus.res_rdata, bus.res_cnt, bus.done);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      fill_rom();
      rand_results();
      do_feed(0, 1'b0, TOTAL, cyc);
      do_drain(4, 2);
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd2, 3'b000}) begin
         miscompares++;
         $display("FAIL rerun_status: got %b expected %b",
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd2, 3'b000});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_watchdog();
      int cyc;
      int n = 0;
      fill_rom();
      do_feed(0, 1'b0, TOTAL, cyc);
      bus.eng_busy = 1'b1;
      while (n < 40) begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
         n++;
         @(posedge clk); #1;
      end
      vectors++;
      if (n !== TIMEOUT) begin
         miscompares++;
         $display("FAIL watchdog_cycles: got %0d DRAIN cycles expected %0d", n, TIMEOUT);
      end
      vectors++;
      if ({bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count} !== {1'b1, 2'd0, 3'b001}) begin
         miscompares++;
         $display("FAIL watchdog_status: got %b expected %b",
                  {bus.done, bus.res_cnt, bus.err_underrun, bus.err_early, bus.err_count}, {1'b1, 2'd0, 3'b001});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.start               = 1'b0;
      bus.eng_busy            = 1'b1;
      bus.eng_out_valid       = 1'b0;
      bus.eng_color_index     = 2'd0;
      bus.eng_image_out_index = '0;
      bus.res_raddr           = '0;
      test_reset();
      test_full_run();
      test_backpressure(1);
      test_backpressure(2);
      test_short_results();
      test_early_result();
      test_overflow();
      test_reset_mid_feed();
      test_watchdog();
      for (int r = 0; r < 4; r++) test_backpressure(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test expected completion");
      $fatal(1, "bench did not complete");
   end
endmodule
`default_nettype wire
